// File: rtl/hex_display_sequencer_if.sv
// Avalon-MM write-only master bus between the HEX sequencer and the PIO bank.
// The sequencer drives address/write/writedata; the slave side returns waitrequest.
interface hex_display_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_writedata,
    input  avm_waitrequest
  );
  modport slave (
    input  avm_address, avm_write, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/hex_display_sequencer.sv
// Snapshots a packed hex digit word, encodes each digit to active-low 7-seg + dp,
// and writes only changed digits (or all, when forced) to per-digit HEX PIO slaves.
module hex_display_sequencer #(
  parameter int                NUM_DIGITS  = 6,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = 16'h0010
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_update_req,
  input  logic                    i_force,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic                    o_busy,
  output logic                    o_done,
  hex_display_sequencer_if.master m
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_NEXT, S_FIN} state_t;

  state_t                r_state, w_nxt;
  logic [3:0]            r_dig   [NUM_DIGITS];
  logic [7:0]            r_cache [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_valid, r_blank, r_dp;
  logic                  r_force, r_pending, r_pend_force;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            w_code;
  logic                  w_dirty, w_snap, w_snap_force, w_last;

  function automatic logic [7:0] enc(input logic [3:0] d, input logic b, input logic p);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return b ? 8'hFF : {~p, s};
  endfunction

  assign w_code  = enc(r_dig[r_idx], r_blank[r_idx], r_dp[r_idx]);
  assign w_dirty = r_force | ~r_valid[r_idx] | (w_code != r_cache[r_idx]);
  assign w_last  = (r_idx == IDX_W'(NUM_DIGITS - 1));
  // Requests landing in FIN fold into the follow-up refresh taken right there.
  assign w_snap  = ((r_state == S_IDLE) && i_update_req) ||
                   ((r_state == S_FIN) && (r_pending || i_update_req));
  assign w_snap_force = (r_state == S_FIN) ? (r_pend_force | (i_update_req & i_force)) : i_force;

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_FIN);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_update_req) w_nxt = S_CHECK;
      S_CHECK: w_nxt = w_dirty ? S_WRITE : S_NEXT;
      S_WRITE: if (!m.avm_waitrequest) w_nxt = S_NEXT;
      S_NEXT:  w_nxt = w_last ? S_FIN : S_CHECK;
      S_FIN:   w_nxt = w_snap ? S_CHECK : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= '0;
      r_force       <= 1'b0;
      r_pending     <= 1'b0;
      r_pend_force  <= 1'b0;
      r_blank       <= '0;
      r_dp          <= '0;
      r_valid       <= '0;
      m.avm_write     <= 1'b0;
      m.avm_address   <= '0;
      m.avm_writedata <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_dig[i]   <= 4'h0;
        r_cache[i] <= 8'hFF;
      end
    end else begin
      m.avm_write <= (w_nxt == S_WRITE);
      if (w_snap) begin
        r_idx   <= '0;
        r_force <= w_snap_force;
        r_blank <= i_blank;
        r_dp    <= i_dp;
        for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= i_digits[4*i +: 4];
      end
      if (r_state == S_FIN) begin
        r_pending    <= 1'b0;
        r_pend_force <= 1'b0;
      end else if ((r_state != S_IDLE) && i_update_req) begin
        r_pending    <= 1'b1;
        r_pend_force <= r_pend_force | i_force;
      end
      if ((r_state == S_CHECK) && w_dirty) begin
        m.avm_address   <= BASE_ADDR + ADDR_W'(r_idx) * ADDR_STRIDE;
        m.avm_writedata <= {24'b0, w_code};
      end
      if ((r_state == S_WRITE) && !m.avm_waitrequest) begin
        r_cache[r_idx] <= m.avm_writedata[7:0];
        r_valid[r_idx] <= 1'b1;
      end
      if ((r_state == S_NEXT) && !w_last) r_idx <= r_idx + 1'b1;
    end
  end
endmodule

// File: doc/hex_display_sequencer.md
Name: hex_display_sequencer

Overview:
Avalon-MM master that drives the bank of 8-bit HEX output PIO slaves of the timer/clock system from one packed digit word. It snapshots the digits on request and encodes each one to active-low seven-segment plus decimal point. It then issues one single-beat write per digit to that digit's PIO data register (offset 0). Unchanged digits are skipped unless a forced refresh is requested, so the Nios II CPU no longer spends cycles on per-digit PIO writes.

Parameters:
NUM_DIGITS, 6, number of HEX PIO slaves driven (1..8)
ADDR_W, 16, master address width (byte addresses)
BASE_ADDR, 16'h0000, byte address of digit 0 PIO data register
ADDR_STRIDE, 16'h0010, byte spacing between consecutive HEX PIO slaves

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
update_req  in  1  one-cycle request to refresh the display
force  in  1  sampled with an accepted update_req; 1 = write every digit regardless of cache
digits  in  4*NUM_DIGITS  packed hex digits; digit i = digits[4i+3:4i]
blank  in  NUM_DIGITS  1 = digit i shows all segments off
dp  in  NUM_DIGITS  1 = decimal point of digit i lit
busy  out  1  high while a refresh is in progress
done  out  1  one-cycle pulse when a refresh completes
avm_address  out  ADDR_W  write address
avm_write  out  1  write strobe
avm_writedata  out  32  write data; [31:8] always 0
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values: busy=0, done=0, avm_write=0, avm_address=0, avm_writedata=0, pending=0. Every cache entry = 8'hFF with its valid bit cleared, so the first refresh writes all digits.
- Encoding, active-low {dp_n, g..a}: blank -> 8'hFF. Otherwise bit7 = ~dp[i] and seg[6:0] for 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Examples: '0' no dp = 8'hC0; '8' with dp = 8'h00.
- FSM states:
  - IDLE: update_req=1 -> snapshot digits/blank/dp/force, index=0, busy=1, go to CHECK.
  - CHECK: compute code(index). If force, or cache invalid, or code != cache[index] -> go to WRITE, setting avm_write=1, avm_address = BASE_ADDR + index*ADDR_STRIDE, avm_writedata = {24'b0, code}. Else -> go to NEXT. One cycle per digit.
  - WRITE: hold address, data and write stable while avm_waitrequest=1. On the first cycle with waitrequest=0: drop avm_write next cycle, update cache[index]=code, set valid, go to NEXT.
  - NEXT: if index = NUM_DIGITS-1 -> go to FIN. Else index+1 -> CHECK.
  - FIN: done=1 for one cycle. If pending -> clear pending, take a new snapshot from the current inputs, go to CHECK with busy held 1. Else busy=0 and go to IDLE.
- Latency: with waitrequest=0 and every digit changed, a full refresh is 1 (accept) + 3*NUM_DIGITS + 1 cycles. A digit is written in its WRITE cycle, which is exactly one cycle.
- update_req while busy (not IDLE) sets pending; any number of requests coalesce into one. The follow-up refresh uses the inputs sampled in FIN. The force values of coalesced requests are ORed into pending_force.
- update_req in the same FIN cycle that pending is already set: still one follow-up refresh only.
- Digits are written in ascending index order. No more than one write is outstanding. avm_write never asserts outside WRITE.
- Inputs changing mid-refresh have no effect on the current refresh, which uses the snapshot.
- Reset mid-write: avm_write drops immediately (asynchronous). Cache is invalidated, so the next refresh rewrites all digits.
- The cache tracks only values this block wrote. Other masters writing the PIOs are not detected; force=1 recovers.

Test Plan:
- After reset, digits=24'h123456, blank=0, dp=0, update_req pulse, waitrequest=0 -> six writes to 0x00,0x10,...,0x50 with data F9,A4,B0,99,92,82 (digit0=6 first: 82 at 0x00), done after 20 cycles.
- Repeat the same inputs, force=0 -> no avm_write, done pulse after 1+2*6+1 cycles. Same with force=1 -> all six writes reissued.
- Change only digit2 to 9 with dp[2]=1 -> a single write of 8'h10 to 0x20.
- waitrequest held high for 5 cycles on digit 0 -> address and data stable for 6 cycles, one write accepted, cache updated once.
- Three update_req pulses while busy, inputs changed to 24'h000000 before FIN -> exactly one follow-up refresh writing C0 to changed digits, two done pulses total.
- Assert reset during WRITE, release, then update_req with unchanged digits -> all six digits rewritten.
